// File: rtl/pcs_transmit_pkg.sv
// Shared types and code-group constants for the 1000BASE-X PCS transmit path.
// Code groups are written abcdeifghj with bit 9 = a.
package pcs_transmit_pkg;

  typedef enum logic [2:0] {
    StIdleK, StIdleD, StStart, StData, StEndT, StEndR, StEndR2
  } tx_state_t;

  typedef enum logic [2:0] {
    KindData, KindIdle, KindComma, KindStart, KindEnd, KindCarrier, KindError
  } tx_kind_t;

  localparam logic [9:0] SetIn     = 10'b0011111010;  // K28.5
  localparam logic [9:0] SetIp     = 10'b1100000101;
  localparam logic [9:0] SetSn     = 10'b1101101000;  // K27.7
  localparam logic [9:0] SetSp     = 10'b0010010111;
  localparam logic [9:0] SetTn     = 10'b1011101000;  // K29.7
  localparam logic [9:0] SetTp     = 10'b0100010111;
  localparam logic [9:0] SetRn     = 10'b1110101000;  // K23.7
  localparam logic [9:0] SetRp     = 10'b0001010111;
  localparam logic [9:0] SetVn     = 10'b0111101000;  // K30.7
  localparam logic [9:0] SetVp     = 10'b1000010111;
  localparam logic [9:0] SetD162n  = 10'b0110110101;
  localparam logic [9:0] SetD162p  = 10'b1001000101;
  localparam logic [9:0] SetD56    = 10'b1010010110;

  localparam logic [7:0] OctD162 = 8'h50;
  localparam logic [7:0] OctD56  = 8'hC5;

  function automatic logic is_supported(input logic [7:0] octet);
    case (octet)
      8'h00, 8'h01, 8'h22, 8'h43, 8'h64,
      8'h85, 8'hA6, 8'hC7, 8'hE8, 8'hE9: is_supported = 1'b1;
      default:                           is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pcs_tx_encoder.sv
// Combinational 8b/10b map for the restricted data subset plus the ordered-set
// control groups; rd = 1 means running disparity is positive.
module pcs_tx_encoder
  import pcs_transmit_pkg::*;
(
  input  logic [7:0] octet,
  input  tx_kind_t   kind,
  input  logic       rd,
  output logic [9:0] code,
  output logic       valid,
  output logic       rd_next
);

  logic [7:0] oct;
  logic [5:0] c6;
  logic [3:0] c4;
  logic       inv6, inv4, rd_mid;
  logic [2:0] ones6;
  logic [3:0] ones10;
  logic [9:0] data_code;

  always_comb begin
    oct = octet;
    if (kind == KindIdle) oct = rd ? OctD162 : OctD56;

    // RD- column; inv marks groups whose RD+ form is the complement
    c6   = 6'b000000;
    inv6 = 1'b0;
    case (oct[4:0])
      5'd0:  begin c6 = 6'b100111; inv6 = 1'b1; end
      5'd1:  begin c6 = 6'b011101; inv6 = 1'b1; end
      5'd2:  begin c6 = 6'b101101; inv6 = 1'b1; end
      5'd3:  c6 = 6'b110001;
      5'd4:  begin c6 = 6'b110101; inv6 = 1'b1; end
      5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;
      5'd7:  begin c6 = 6'b111000; inv6 = 1'b1; end
      5'd8:  begin c6 = 6'b111001; inv6 = 1'b1; end
      5'd9:  c6 = 6'b100101;
      5'd16: begin c6 = 6'b011011; inv6 = 1'b1; end
      default: ;
    endcase
    if (inv6 && rd) c6 = ~c6;

    ones6  = 3'($countones(c6));
    rd_mid = (ones6 > 3'd3) ? 1'b1 : (ones6 < 3'd3) ? 1'b0 : rd;

    c4   = 4'b0000;
    inv4 = 1'b0;
    case (oct[7:5])
      3'd0: begin c4 = 4'b1011; inv4 = 1'b1; end
      3'd1: c4 = 4'b1001;
      3'd2: c4 = 4'b0101;
      3'd3: begin c4 = 4'b1100; inv4 = 1'b1; end
      3'd4: begin c4 = 4'b1101; inv4 = 1'b1; end
      3'd5: c4 = 4'b1010;
      3'd6: c4 = 4'b0110;
      default: begin c4 = 4'b1110; inv4 = 1'b1; end
    endcase
    if (inv4 && rd_mid) c4 = ~c4;

    data_code = {c6, c4};

    code  = data_code;
    valid = 1'b1;
    unique case (kind)
      KindData: begin
        if (!is_supported(octet)) begin
          code  = rd ? SetVp : SetVn;
          valid = 1'b0;
        end
      end
      KindIdle:    code = data_code;
      KindComma:   code = rd ? SetIp : SetIn;
      KindStart:   code = rd ? SetSp : SetSn;
      KindEnd:     code = rd ? SetTp : SetTn;
      KindCarrier: code = rd ? SetRp : SetRn;
      KindError: begin
        code  = rd ? SetVp : SetVn;
        valid = 1'b0;
      end
      default: ;
    endcase

    ones10  = 4'($countones(code));
    rd_next = (ones10 == 4'd6) ? 1'b1 : (ones10 == 4'd4) ? 1'b0 : rd;
  end

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: GMII octets in, one registered 10-bit code group out per
// clock, with idle generation, frame delimiters and even-slot realignment.
module pcs_transmit
  import pcs_transmit_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TXD,
  input  logic       TX_EN,
  input  logic       TX_ER,
  output logic [9:0] PUDR,
  output logic       TX_EVEN,
  output logic       TRANSMITTING,
  output logic       TX_CODE_ERR
);

  tx_state_t  state_q, state_d;
  tx_kind_t   kind;
  logic       rd_q, rd_next, valid;
  logic [9:0] code;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdleK:         state_d = StIdleD;
      StIdleD:         state_d = TX_EN ? StStart : StIdleK;
      StStart, StData: state_d = TX_EN ? StData : StEndT;
      StEndT:          state_d = StEndR;
      // TX_EVEN is the slot of the /R/ currently on the pins
      StEndR:          state_d = TX_EVEN ? StEndR2 : StIdleK;
      StEndR2:         state_d = StIdleK;
      default:         state_d = StIdleK;
    endcase
  end

  always_comb begin
    kind = KindComma;
    case (state_d)
      StIdleK:         kind = KindComma;
      StIdleD:         kind = KindIdle;
      StStart:         kind = KindStart;
      StData:          kind = TX_ER ? KindError : KindData;
      StEndT:          kind = KindEnd;
      StEndR, StEndR2: kind = KindCarrier;
      default:         kind = KindComma;
    endcase
  end

  pcs_tx_encoder u_encoder (
    .octet   (TXD),
    .kind    (kind),
    .rd      (rd_q),
    .code    (code),
    .valid   (valid),
    .rd_next (rd_next)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdleD;
      rd_q         <= 1'b0;
      PUDR         <= 10'b0;
      TX_EVEN      <= 1'b0;
      TRANSMITTING <= 1'b0;
      TX_CODE_ERR  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_next;
      PUDR         <= code;
      TX_EVEN      <= ~TX_EVEN;
      TRANSMITTING <= (state_d == StStart) || (state_d == StData);
      TX_CODE_ERR  <= ~valid;
    end
  end

endmodule

// File: tb/tb_pcs_transmit.sv
// Directed-vector bench for pcs_transmit; each vector drives inputs for one edge and
// compares {PUDR, TX_EVEN, TRANSMITTING, TX_CODE_ERR} just after it.
module tb_pcs_transmit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic [9:0] PUDR;
  logic       TX_EVEN;
  logic       TRANSMITTING;
  logic       TX_CODE_ERR;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] K28N = 10'b0011111010;
  localparam logic [9:0] K28P = 10'b1100000101;
  localparam logic [9:0] I2   = 10'b1001000101;
  localparam logic [9:0] I1   = 10'b1010010110;
  localparam logic [9:0] SN   = 10'b1101101000;
  localparam logic [9:0] TN   = 10'b1011101000;
  localparam logic [9:0] TP   = 10'b0100010111;
  localparam logic [9:0] RN   = 10'b1110101000;
  localparam logic [9:0] RP   = 10'b0001010111;
  localparam logic [9:0] VN   = 10'b0111101000;
  localparam logic [9:0] D00N = 10'b1001110100;
  localparam logic [9:0] D21N = 10'b1011011001;
  localparam logic [9:0] D32N = 10'b1100010101;

  typedef struct packed {
    logic        en;
    logic        er;
    logic [7:0]  txd;
    logic [12:0] exp;
  } vec_t;

  logic [12:0] obs;
  assign obs = {PUDR, TX_EVEN, TRANSMITTING, TX_CODE_ERR};

  pcs_transmit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .TXD          (TXD),
    .TX_EN        (TX_EN),
    .TX_ER        (TX_ER),
    .PUDR         (PUDR),
    .TX_EVEN      (TX_EVEN),
    .TRANSMITTING (TRANSMITTING),
    .TX_CODE_ERR  (TX_CODE_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic en, input logic er, input logic [7:0] txd,
                              input logic [9:0] pudr, input logic even,
                              input logic trans, input logic err);
    mk = '{en: en, er: er, txd: txd, exp: {pudr, even, trans, err}};
  endfunction

  task automatic test_reset();
    vec_t v [4];
    RESET = 1'b0; TX_EN = 1'b0; TX_ER = 1'b0; TXD = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", obs, 13'b0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    v[0] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[1] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    v[2] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[3] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL idle_pattern[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  task automatic test_frame_start();
    vec_t v [3];
    v[0] = mk(1, 0, 8'h00, SN,   1, 1, 0);
    v[1] = mk(1, 0, 8'h00, D00N, 0, 1, 0);
    v[2] = mk(1, 0, 8'h00, D00N, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL frame_start[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  task automatic test_odd_end();
    vec_t v [5];
    v[0] = mk(0, 0, 8'h00, TN,   0, 0, 0);
    v[1] = mk(0, 0, 8'h00, RN,   1, 0, 0);
    v[2] = mk(0, 0, 8'h00, RN,   0, 0, 0);
    v[3] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[4] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL odd_end[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  // D2.1 leaves RD positive, so the tail and next idle use the RD+ column and /I1/
  task automatic test_even_end();
    vec_t v [8];
    v[0] = mk(1, 0, 8'h22, SN,   1, 1, 0);
    v[1] = mk(1, 0, 8'h22, D21N, 0, 1, 0);
    v[2] = mk(0, 0, 8'h00, TP,   1, 0, 0);
    v[3] = mk(0, 0, 8'h00, RP,   0, 0, 0);
    v[4] = mk(0, 0, 8'h00, K28P, 1, 0, 0);
    v[5] = mk(0, 0, 8'h00, I1,   0, 0, 0);
    v[6] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[7] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL even_end[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  task automatic test_error();
    vec_t v [8];
    v[0] = mk(1, 0, 8'h01, SN,   1, 1, 0);
    v[1] = mk(1, 1, 8'h01, VN,   0, 1, 1);
    v[2] = mk(1, 0, 8'hFF, VN,   1, 1, 1);
    v[3] = mk(1, 0, 8'h43, D32N, 0, 1, 0);
    v[4] = mk(0, 1, 8'h00, TN,   1, 0, 0);
    v[5] = mk(0, 1, 8'h00, RN,   0, 0, 0);
    v[6] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[7] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL error_octets[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  // TX_EN during IDLE_K and END_* is ignored; a zero-octet frame still pads to even
  task automatic test_discard();
    vec_t v [8];
    v[0] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[1] = mk(1, 0, 8'h00, I2,   0, 0, 0);
    v[2] = mk(1, 0, 8'h00, SN,   1, 1, 0);
    v[3] = mk(0, 0, 8'h00, TN,   0, 0, 0);
    v[4] = mk(1, 0, 8'h00, RN,   1, 0, 0);
    v[5] = mk(1, 0, 8'h00, RN,   0, 0, 0);
    v[6] = mk(1, 0, 8'h00, K28N, 1, 0, 0);
    v[7] = mk(1, 0, 8'h00, I2,   0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL discard[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    vec_t v [6];
    v[0] = mk(1, 0, 8'h00, SN,   1, 1, 0);
    v[1] = mk(1, 0, 8'h00, D00N, 0, 1, 0);
    v[2] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[3] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    v[4] = mk(0, 0, 8'h00, K28N, 1, 0, 0);
    v[5] = mk(0, 0, 8'h00, I2,   0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL mid_reset_pre[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got %b want %b", obs, 13'b0);
    end
    @(posedge CLK); #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL mid_reset_held: got %b want %b", obs, 13'b0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 2; i < 6; i++) begin
      TX_EN = v[i].en; TX_ER = v[i].er; TXD = v[i].txd;
      @(posedge CLK); #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL mid_reset_post[%0d]: got %b want %b", i, obs, v[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_odd_end();
    test_even_end();
    test_error();
    test_discard();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_transmit.md
# pcs_transmit

Clause-36-style 1000BASE-X PCS transmit path: the transmit counterpart of the `synchronization` receive block. It accepts GMII-style octets (`TXD`, `TX_EN`, `TX_ER`) and emits one 10-bit code group per clock on `PUDR`, toward the PMA/loopback path that feeds `PUDI`. It handles ordered-set generation (/I/, /S/, /T/, /R/, /V/), even/odd slot alignment, and running disparity (RD), using the same restricted data code-group subset the receiver accepts.

## Interface
- No parameters. All code-group constants come from `PARAMETERS.v`.
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `TXD` in 8: octet, Dx.y = {y[2:0], x[4:0]}.
- `TX_EN` in 1: frame enable.
- `TX_ER` in 1: transmit error; while `TX_EN`=1, forces /V/.
- `PUDR` out 10: code group; bit 9 = `a`, bit 0 = `j`. This is the same ordering as `PUDI`.
- `TX_EVEN` out 1: 1 when the current `PUDR` occupies an even slot.
- `TRANSMITTING` out 1: 1 while in START or DATA.
- `TX_CODE_ERR` out 1: 1-cycle pulse, high in any cycle where `PUDR` carries /V/.

## Operation
**State register.** States: IDLE_K, IDLE_D, START, DATA, END_T, END_R, END_R2.
- Each rising edge: state <= next, and all outputs are registered from (next, `TXD`, `TX_ER`, RD).

**Slot parity.** `TX_EVEN` toggles every cycle without exception.

**Code group emitted per state:**
- IDLE_K: K28.5, always in an even slot.
- IDLE_D: odd slot. Emit D16.2 (/I2/) if RD is + at emission, otherwise D5.6 (/I1/).
- START: /S/ (K27.7).
- DATA: `TXD` encoded. Emit /V/ (K30.7) if `TX_ER`=1 or `TXD` is outside the supported subset.
  - Supported subset: D0.0, D1.0, D2.1, D3.2, D4.3, D5.4, D6.5, D7.6, D8.7, D9.7.
- END_T: /T/ (K29.7).
- END_R and END_R2: /R/ (K23.7).

**Transitions** (`TX_EN` is sampled at the same edge):
- IDLE_K -> IDLE_D unconditionally. An octet sampled here is discarded.
- IDLE_D -> START if `TX_EN`=1, else IDLE_K. The octet sampled here is replaced by /S/.
- START or DATA -> DATA if `TX_EN`=1, else END_T.
- END_T -> END_R.
- END_R -> IDLE_K if its /R/ went out in an odd slot; -> END_R2 if it went out in an even slot.
- END_R2 -> IDLE_K.
- `TX_EN` asserted during END_* or IDLE_K: those octets are discarded. A frame can only start from IDLE_D.

**Running disparity.**
- Column selection: suffix `n` = column used when the current RD is negative; suffix `p` = column used when RD is positive.
- After each code group, based on its ones count:
  - 6 ones -> RD becomes +.
  - 4 ones -> RD becomes −.
  - 5 ones -> RD unchanged.
- RD resets to −.

**Reset values.** `PUDR`=10'b0, `TX_EVEN`=0, `TRANSMITTING`=0, `TX_CODE_ERR`=0, RD=−. State resets to IDLE_D, so the first code group after reset is an even-slot K28.5.

## Timing
- `TXD`, `TX_EN` and `TX_ER` sampled at edge k determine `PUDR` during cycle k (the output after edge k). This gives 1 cycle of latency from input to pin.
- The /S/ slot is always even.
- /T/ may land in either slot. Trailing /R/ groups pad the end of frame so that the next IDLE_K falls in an even slot.
- Asynchronous reset mid-frame truncates the frame without emitting /T/. Outputs take their reset values immediately.
- `TX_ER`=1 with `TX_EN`=0 has no effect.

## Structure
- Additions to `PARAMETERS.v`:
  - `set_D_16_2p` / `set_D_16_2n`
  - `set_D_5_6` (balanced; same code group for both RD values)
  - `set_Vp` / `set_Vn`
  - State encodings as localparams.
- `set_Ip` / `set_In` are K28.5.
- One sub-module, `pcs_tx_encoder`: a combinational map (octet, is_control kind, RD) -> (10-bit group, valid, next RD).

## Test plan
- **Reset idle pattern.** Release reset with `TX_EN`=0 -> `PUDR` alternates 0011111010 (`TX_EVEN`=1) and 1001000101 (`TX_EVEN`=0). RD ends − after every pair.
- **Frame starting from IDLE_D.** Raise `TX_EN` at an IDLE_D edge and send `TXD`=0x00 for 3 cycles -> outputs /S/ (1101101000), then D0.0 (1001110100), then D0.0 in the RD+ column if RD flipped. `TRANSMITTING`=1 throughout.
- **Odd-slot end.** Frame of 2 data octets, so /T/ lands odd -> /T/, /R/ (even), /R/ (odd), then K28.5 (even).
- **Even-slot end.** Frame of 1 data octet, so /T/ lands even -> /T/, /R/ (odd), then K28.5 (even). No END_R2.
- **Error and unsupported octets.** Assert `TX_ER` mid-frame, or send `TXD`=0xFF -> /V/ (0111101000 when RD=−). `TX_CODE_ERR` pulses for exactly that cycle.
- **Reset mid-frame.** Assert `RESET`=0 during DATA -> `PUDR`=0 asynchronously. After release, /T/ is never emitted and the idle pattern restarts with K28.5 RD− in an even slot.
